// File: rtl/sparce_unit.sv
// SPARCE skip unit: tracks which architectural registers hold zero, holds a
// small table of skippable code regions, and redirects fetch past a region
// when its trigger PC is fetched and its source operand(s) are known zero.
module sparce_unit #(
    parameter int          SASA_ENTRIES = 16,
    parameter logic [31:0] SASA_BASE    = 32'h0000_2000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc,
    input  logic [31:0] rdata,
    input  logic        if_ex_enable,
    input  logic        wb_en,
    input  logic [4:0]  rd,
    input  logic [31:0] wb_data,
    input  logic        sasa_wen,
    input  logic [31:0] sasa_addr,
    input  logic [31:0] sasa_data,
    output logic        skipping,
    output logic [31:0] sparce_target
);

    localparam int          IW        = $clog2(SASA_ENTRIES);
    localparam logic [31:0] WIN_BYTES = 32'(8 * SASA_ENTRIES);

    // Skip table: trigger PC (word-aligned) and decoded config word
    logic [29:0]             trig_q [SASA_ENTRIES];
    logic [11:0]             len_q  [SASA_ENTRIES];
    logic [4:0]              rs1_q  [SASA_ENTRIES];
    logic [4:0]              rs2_q  [SASA_ENTRIES];
    logic [SASA_ENTRIES-1:0] mode_q;
    logic [SASA_ENTRIES-1:0] tbl_vld_q;

    logic [31:0] spv_q;
    logic [31:0] spv_nxt;

    // Two most recent fetched instructions whose result is not yet written back
    logic [1:0]  trk_vld_q;
    logic [1:0]  trk_vld_c;
    logic [4:0]  trk_rd_q [2];
    logic        new_vld;

    logic        skip_p1;
    logic        hold_p1;
    logic [31:0] tgt_p1;

    logic          hit;
    logic          cond;
    logic          fire;
    logic [IW-1:0] sel;
    logic [31:0]   tgt_nxt;

    logic          in_win;
    logic [31:0]   win_off;
    logic [IW-1:0] wr_idx;

    logic unused_bits;
    assign unused_bits = ^{rdata[31:12], sasa_data[19:12]};

    // Opcodes that produce a register result (R, I-arith, load, LUI, AUIPC, JAL, JALR)
    function automatic logic is_tracked_op(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // A register is zero only if the vector says so and no in-flight write targets it
    function automatic logic reg_zero(input logic [4:0] r, input logic [31:0] spv,
                                      input logic [1:0] tv, input logic [4:0] t0,
                                      input logic [4:0] t1);
        return spv[r] && !(tv[0] && (t0 == r)) && !(tv[1] && (t1 == r));
    endfunction

    assign win_off = sasa_addr - SASA_BASE;
    assign in_win  = (sasa_addr >= SASA_BASE) && (win_off < WIN_BYTES);
    assign wr_idx  = sasa_addr[3 +: IW];

    assign new_vld      = is_tracked_op(rdata[6:0]) && (rdata[11:7] != 5'd0);
    assign trk_vld_c[0] = trk_vld_q[0] && !(wb_en && (rd == trk_rd_q[0]));
    assign trk_vld_c[1] = trk_vld_q[1] && !(wb_en && (rd == trk_rd_q[1]));

    // Next-state sparsity vector; also used directly so a same-cycle writeback is seen
    always_comb begin
        spv_nxt = spv_q;
        if (wb_en && (rd != 5'd0))
            spv_nxt[rd] = (wb_data == 32'd0);
        spv_nxt[0] = 1'b1;
    end

    // Table lookup: descending scan so the lowest matching index is the one kept
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
            if (tbl_vld_q[i] && (len_q[i] != 12'd0) && ({trig_q[i], 2'b00} == pc)) begin
                hit = 1'b1;
                sel = IW'(i);
            end
        end
    end

    assign cond = reg_zero(rs1_q[sel], spv_nxt, trk_vld_c, trk_rd_q[0], trk_rd_q[1]) ||
                  (mode_q[sel] &&
                   reg_zero(rs2_q[sel], spv_nxt, trk_vld_c, trk_rd_q[0], trk_rd_q[1]));
    assign tgt_nxt = {trig_q[sel], 2'b00} + {18'd0, len_q[sel], 2'b00};
    assign fire    = if_ex_enable && hit && cond && !skip_p1 && !hold_p1;

    // Sparsity vector register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) spv_q <= '1;
        else       spv_q <= spv_nxt;
    end

    // Tracker valid bits: shift on advance, writeback clears in the shifted position
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)             trk_vld_q <= '0;
        else if (if_ex_enable) trk_vld_q <= {trk_vld_c[0], new_vld};
        else                   trk_vld_q <= trk_vld_c;
    end

    // Tracker destination registers
    always_ff @(posedge CLK) begin
        if (if_ex_enable) begin
            trk_rd_q[1] <= trk_rd_q[0];
            trk_rd_q[0] <= rdata[11:7];
        end
    end

    // Table valid bits written from the config window
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            tbl_vld_q <= '0;
        else if (sasa_wen && in_win && sasa_addr[2])
            tbl_vld_q[wr_idx] <= sasa_data[31];
    end

    // Table data fields written from the config window
    always_ff @(posedge CLK) begin
        if (sasa_wen && in_win) begin
            if (!sasa_addr[2]) begin
                trig_q[wr_idx] <= sasa_data[31:2];
            end else begin
                mode_q[wr_idx] <= sasa_data[30];
                rs1_q[wr_idx]  <= sasa_data[29:25];
                rs2_q[wr_idx]  <= sasa_data[24:20];
                len_q[wr_idx]  <= sasa_data[11:0];
            end
        end
    end

    // ---- stage p1: skip pulse, holdoff and redirect target ----
    // Skip pulse and holdoff advance only with the pipeline
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            skip_p1 <= 1'b0;
            hold_p1 <= 1'b0;
            tgt_p1  <= '0;
        end else if (if_ex_enable) begin
            skip_p1 <= fire;
            hold_p1 <= skip_p1;
            if (fire)
                tgt_p1 <= tgt_nxt;
        end
    end

    assign skipping      = skip_p1;
    assign sparce_target = tgt_p1;

endmodule

// File: tb/tb_sparce_unit.sv
// Self-checking bench for sparce_unit: directed scenarios followed by random
// traffic, all compared against a behavioural model of the skip rules.
module tb_sparce_unit;

    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        CLK;
    logic        nRST;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        if_ex_enable;
    logic        wb_en;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        sasa_wen;
    logic [31:0] sasa_addr;
    logic [31:0] sasa_data;
    logic        skipping;
    logic [31:0] sparce_target;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [31:0] m_w0 [16];
    bit [31:0] m_w1 [16];
    bit [31:0] m_zero;
    int        trk [$];
    bit        m_skip;
    bit        m_hold;
    bit [31:0] m_tgt;

    sparce_unit #(.SASA_ENTRIES(16), .SASA_BASE(BASE)) dut (
        .CLK(CLK), .nRST(nRST), .pc(pc), .rdata(rdata), .if_ex_enable(if_ex_enable),
        .wb_en(wb_en), .rd(rd), .wb_data(wb_data), .sasa_wen(sasa_wen),
        .sasa_addr(sasa_addr), .sasa_data(sasa_data), .skipping(skipping),
        .sparce_target(sparce_target)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] w1(input bit v, input bit mode, input int r1, input int r2,
                                     input int len);
        bit [31:0] w;
        w        = '0;
        w[31]    = v;
        w[30]    = mode;
        w[29:25] = 5'(r1);
        w[24:20] = 5'(r2);
        w[11:0]  = 12'(len);
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_w1[i][31] = 1'b0;
        m_zero = '1;
        trk    = {0, 0};
        m_skip = 1'b0;
        m_hold = 1'b0;
        m_tgt  = '0;
    endtask

    function automatic bit is_zero(input int r, input bit [31:0] z, input int tk[$]);
        bool_busy: begin end
        if (!z[r]) return 1'b0;
        foreach (tk[k]) if (tk[k] != 0 && tk[k] == r) return 1'b0;
        return 1'b1;
    endfunction

    // One clock edge of the skip rules, using the inputs currently driven
    task automatic model_step();
        bit [31:0] zn;
        int        tk[$];
        int        win;
        bit        c;
        bit        f;
        bit [6:0]  op;
        int        nr;
        int        idx;
        bit [31:0] w;
        if (!nRST) begin
            model_reset();
            return;
        end
        zn = m_zero;
        if (wb_en && rd != 0) zn[rd] = (wb_data == 0);
        zn[0] = 1'b1;
        tk = trk;
        foreach (tk[k]) if (wb_en && tk[k] == int'(rd)) tk[k] = 0;
        win = -1;
        for (int i = 0; i < 16; i++) begin
            w = m_w1[i];
            if (w[31] && w[11:0] != 0 && m_w0[i] == pc) begin
                win = i;
                break;
            end
        end
        c = 1'b0;
        if (win >= 0) begin
            w = m_w1[win];
            c = is_zero(int'(w[29:25]), zn, tk) || (w[30] && is_zero(int'(w[24:20]), zn, tk));
        end
        if (if_ex_enable) begin
            f      = (win >= 0) && c && !m_skip && !m_hold;
            m_hold = m_skip;
            m_skip = f;
            if (f) begin
                w     = m_w1[win];
                m_tgt = m_w0[win] + {18'd0, w[11:0], 2'b00};
            end
        end
        if (sasa_wen && sasa_addr >= BASE && sasa_addr < BASE + 32'd128) begin
            idx = int'((sasa_addr >> 3) & 32'd15);
            if (sasa_addr[2]) m_w1[idx] = sasa_data;
            else              m_w0[idx] = sasa_data & 32'hFFFF_FFFC;
        end
        if (if_ex_enable) begin
            op = rdata[6:0];
            nr = 0;
            if ((op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                            7'b0010111, 7'b1101111, 7'b1100111}) && rdata[11:7] != 0)
                nr = int'(rdata[11:7]);
            tk.push_front(nr);
            void'(tk.pop_back());
        end
        trk    = tk;
        m_zero = zn;
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk("skipping", {31'd0, skipping}, {31'd0, m_skip});
        chk("target", sparce_target, m_tgt);
    endtask

    task automatic idle();
        if_ex_enable = 1'b0;
        wb_en        = 1'b0;
        rd           = '0;
        wb_data      = '0;
        sasa_wen     = 1'b0;
        sasa_addr    = '0;
        sasa_data    = '0;
        rdata        = '0;
        pc           = '0;
    endtask

    task automatic store(input bit [31:0] a, input bit [31:0] d);
        idle();
        sasa_wen  = 1'b1;
        sasa_addr = a;
        sasa_data = d;
        tick();
        idle();
    endtask

    task automatic program_entry(input int idx, input bit [31:0] trig, input bit [31:0] cfg);
        store(BASE + 32'(idx * 8), trig);
        store(BASE + 32'(idx * 8 + 4), cfg);
    endtask

    task automatic wbw(input int r, input bit [31:0] d);
        idle();
        wb_en   = 1'b1;
        rd      = 5'(r);
        wb_data = d;
        tick();
        idle();
    endtask

    task automatic fetch(input bit [31:0] p, input bit [31:0] ins);
        idle();
        if_ex_enable = 1'b1;
        pc           = p;
        rdata        = ins;
        tick();
        idle();
    endtask

    task automatic async_reset();
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        chk("async_rst_skip", {31'd0, skipping}, 32'd0);
        chk("async_rst_tgt", sparce_target, 32'd0);
    endtask

    initial begin
        bit [31:0] pool [5];
        bit [31:0] addi_x5;
        pool    = '{32'h100, 32'h200, 32'h300, 32'hFFFF_FFFC, 32'h104};
        addi_x5 = {12'd0, 5'd0, 3'b000, 5'd5, 7'b0010011};
        for (int i = 0; i < 16; i++) begin
            m_w0[i] = '0;
            m_w1[i] = '0;
        end
        nRST = 1'b1;
        idle();
        #2;
        nRST = 1'b0;
        model_reset();
        tick();
        tick();
        chk("reset_skip", {31'd0, skipping}, 32'd0);
        chk("reset_tgt", sparce_target, 32'd0);
        #2;
        nRST = 1'b1;

        // Basic skip on x5 == 0, then pulse/holdoff behaviour
        program_entry(0, 32'h100, w1(1, 0, 5, 0, 4));
        wbw(5, 32'd0);
        fetch(32'h100, 0);
        chk("basic_skip", {31'd0, skipping}, 32'd1);
        chk("basic_tgt", sparce_target, 32'h110);
        fetch(32'h0, 0);
        chk("pulse_end", {31'd0, skipping}, 32'd0);
        fetch(32'h100, 0);
        chk("holdoff", {31'd0, skipping}, 32'd0);
        fetch(32'h100, 0);
        chk("after_holdoff", {31'd0, skipping}, 32'd1);
        fetch(0, 0);
        fetch(0, 0);

        // Nonzero source blocks; same-cycle zero writeback is bypassed
        wbw(5, 32'd7);
        fetch(32'h100, 0);
        chk("nonzero_noskip", {31'd0, skipping}, 32'd0);
        idle();
        if_ex_enable = 1'b1;
        pc           = 32'h100;
        wb_en        = 1'b1;
        rd           = 5'd5;
        wb_data      = 32'd0;
        tick();
        idle();
        chk("bypass_skip", {31'd0, skipping}, 32'd1);
        fetch(0, 0);
        fetch(0, 0);

        // In-flight producer of x5 blocks until its writeback
        fetch(0, addi_x5);
        fetch(32'h100, 0);
        chk("inflight_block", {31'd0, skipping}, 32'd0);
        wbw(5, 32'd0);
        fetch(32'h100, 0);
        chk("inflight_cleared", {31'd0, skipping}, 32'd1);
        fetch(0, 0);
        fetch(0, 0);

        // Lowest index wins
        program_entry(2, 32'h200, w1(1, 0, 0, 0, 1));
        program_entry(7, 32'h200, w1(1, 0, 0, 0, 3));
        fetch(32'h200, 0);
        chk("prio_skip", {31'd0, skipping}, 32'd1);
        chk("prio_tgt", sparce_target, 32'h204);
        fetch(0, 0);
        fetch(0, 0);

        // Stores outside the window leave the table alone
        store(BASE + 32'h80, 32'h300);
        store(BASE + 32'h84, 32'h0);
        store(BASE - 32'h4, 32'h0);
        fetch(32'h100, 0);
        chk("window_skip", {31'd0, skipping}, 32'd1);
        chk("window_tgt", sparce_target, 32'h110);
        fetch(0, 0);
        fetch(0, 0);

        // len 0 never skips; target wraps modulo 2^32
        program_entry(3, 32'h400, w1(1, 0, 0, 0, 0));
        fetch(32'h400, 0);
        chk("len0_noskip", {31'd0, skipping}, 32'd0);
        program_entry(4, 32'hFFFF_FFFC, w1(1, 0, 0, 0, 1));
        fetch(32'hFFFF_FFFC, 0);
        chk("wrap_skip", {31'd0, skipping}, 32'd1);
        chk("wrap_tgt", sparce_target, 32'h0);
        fetch(0, 0);
        fetch(0, 0);

        // Mode 1 uses either source; mode 0 only rs1
        wbw(6, 32'd9);
        program_entry(5, 32'h500, w1(1, 1, 6, 0, 2));
        program_entry(6, 32'h600, w1(1, 0, 6, 0, 2));
        fetch(32'h600, 0);
        chk("mode0_noskip", {31'd0, skipping}, 32'd0);
        fetch(32'h500, 0);
        chk("mode1_skip", {31'd0, skipping}, 32'd1);
        chk("mode1_tgt", sparce_target, 32'h508);
        fetch(0, 0);
        fetch(0, 0);

        // Same-cycle store does not affect the lookup in flight
        idle();
        if_ex_enable = 1'b1;
        pc           = 32'h500;
        sasa_wen     = 1'b1;
        sasa_addr    = BASE + 32'd44;
        sasa_data    = 32'd0;
        tick();
        idle();
        chk("old_contents", {31'd0, skipping}, 32'd1);
        fetch(0, 0);
        fetch(0, 0);
        fetch(32'h500, 0);
        chk("new_contents", {31'd0, skipping}, 32'd0);

        // Stall holds the pulse; async reset drops it immediately
        fetch(32'h200, 0);
        tick();
        tick();
        tick();
        chk("stall_hold", {31'd0, skipping}, 32'd1);
        async_reset();
        tick();
        #2;
        nRST = 1'b1;
        fetch(32'h200, 0);
        chk("post_rst_invalid", {31'd0, skipping}, 32'd0);
        program_entry(2, 32'h200, w1(1, 0, 0, 0, 1));
        fetch(32'h200, 0);
        chk("post_rst_x0", {31'd0, skipping}, 32'd1);
        chk("post_rst_tgt", sparce_target, 32'h204);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            bit [31:0] d;
            if_ex_enable = ($urandom_range(0, 3) != 0);
            pc = ($urandom_range(0, 4) != 0) ? pool[$urandom_range(0, 4)] : $urandom;
            d = $urandom;
            case ($urandom_range(0, 3))
                0: d[6:0] = 7'b0010011;
                1: d[6:0] = 7'b0000011;
                2: d[6:0] = 7'b1101111;
                default: d[6:0] = 7'b1100011;
            endcase
            d[11:7] = 5'($urandom_range(0, 7));
            rdata   = d;
            wb_en   = ($urandom_range(0, 2) == 0);
            rd      = 5'($urandom_range(0, 7));
            wb_data = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            sasa_wen  = ($urandom_range(0, 5) == 0);
            sasa_addr = BASE - 32'd8 + 32'($urandom_range(0, 35) * 4);
            if (sasa_addr[2])
                sasa_data = w1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                               $urandom_range(0, 7), $urandom_range(0, 7),
                               ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 4095));
            else
                sasa_data = pool[$urandom_range(0, 4)] | 32'($urandom_range(0, 3));
            tick();
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
                #1;
                nRST = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
